sum_seg_display: RTL and testbench

//  Downstream consumer of the 4-bit registered adder. Captures the 5-bit result
//  {Overflow,Sum} (0..30) and converts it to two decimal digits (tens, ones).

---
 rtl/sum_seg_display.sv | 118 +++++++++++
 tb/tb_sum_seg_display.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sum_seg_display.sv
// Captures the 5-bit adder result {Overflow,Sum}, splits it into decimal tens/ones
// and scans them onto a 2-digit seven-segment display. OVF_BLINK_EN adds overflow blinking.
module sum_seg_display #(
  parameter int SCAN_BITS      = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int BLINK_BITS     = 24
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Load,
  input  logic [3:0] Sum,
  input  logic       Overflow,
  output logic [6:0] Seg,
  output logic       Dp,
  output logic [1:0] An
);

  localparam logic INACT = SEG_ACTIVE_LOW;

  logic [4:0]           val_q, val_d;
  logic [SCAN_BITS-1:0] scan_cnt_q, scan_cnt_d;
  logic                 dig_sel_q, dig_sel_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic [1:0]           an_q, an_d;

  logic [1:0] tens_w;
  logic [3:0] ones_w;
  logic [6:0] seg_act;
  logic       dp_act;
  logic [1:0] an_act;

  function automatic logic [6:0] seg_code(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h00;
    endcase
  endfunction

  // 31 is unreachable from the adder but still decodes as tens=3, ones=1.
  always_comb begin
    if (val_q >= 5'd30)      tens_w = 2'd3;
    else if (val_q >= 5'd20) tens_w = 2'd2;
    else if (val_q >= 5'd10) tens_w = 2'd1;
    else                     tens_w = 2'd0;
  end
  assign ones_w = 4'(val_q - 5'd10 * {3'b000, tens_w});

`ifdef OVF_BLINK_EN
  logic [BLINK_BITS-1:0] blink_cnt_q;
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) blink_cnt_q <= '0;
    else     blink_cnt_q <= blink_cnt_q + 1'b1;
  end
`else
  logic [31:0] unused_blink_bits;
  assign unused_blink_bits = BLINK_BITS;
`endif

  always_comb begin
    val_d      = Load ? {Overflow, Sum} : val_q;
    scan_cnt_d = scan_cnt_q + 1'b1;
    dig_sel_d  = dig_sel_q ^ (&scan_cnt_q);
    seg_act    = 7'h00;
    dp_act     = 1'b0;
    an_act     = 2'b00;
    if (!dig_sel_q) begin
      an_act  = 2'b01;
      seg_act = seg_code(ones_w);
      dp_act  = val_q[4];
    end else begin
      an_act  = 2'b10;
      seg_act = (tens_w == 2'd0) ? 7'h00 : seg_code({2'b00, tens_w});
    end
`ifdef OVF_BLINK_EN
    if (val_q[4] && blink_cnt_q[BLINK_BITS-1]) begin
      seg_act = 7'h00;
      dp_act  = 1'b0;
    end
`endif
    // Polarity is applied before the output flops so the pins come straight from registers.
    seg_d = seg_act ^ {7{INACT}};
    dp_d  = dp_act ^ INACT;
    an_d  = an_act ^ {2{INACT}};
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      val_q      <= '0;
      scan_cnt_q <= '0;
      dig_sel_q  <= 1'b0;
      seg_q      <= {7{INACT}};
      dp_q       <= INACT;
      an_q       <= {2{INACT}};
    end else begin
      val_q      <= val_d;
      scan_cnt_q <= scan_cnt_d;
      dig_sel_q  <= dig_sel_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  assign Seg = seg_q;
  assign Dp  = dp_q;
  assign An  = an_q;

endmodule

// File: tb/tb_sum_seg_display.sv
// Bench for sum_seg_display with SCAN_BITS=2, active-low outputs, BLINK_BITS=4.
// Table of loaded values with hand-decoded segment patterns, plus scan/reset/blink sequences.
module tb_sum_seg_display;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       Load;
  logic [3:0] Sum;
  logic       Overflow;
  logic [6:0] Seg;
  logic       Dp;
  logic [1:0] An;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] sum;
    logic       ovf;
    logic [6:0] ones_seg;
    logic [6:0] tens_seg;
    logic       ones_dp;
  } vec_t;

  vec_t vecs[10];
  logic [9:0] exp_q[$];

  always #5 Clk = ~Clk;

  sum_seg_display #(
    .SCAN_BITS(2),
    .SEG_ACTIVE_LOW(1'b1),
    .BLINK_BITS(4)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .Load(Load),
    .Sum(Sum),
    .Overflow(Overflow),
    .Seg(Seg),
    .Dp(Dp),
    .An(An)
  );

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%02h expected=%02h", name, got, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge Clk);
    Rst  = 1'b1;
    Load = 1'b0;
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  initial begin
    logic [9:0] exp_w;
    logic [6:0] exp_seg;
    logic       exp_dp;
    int         blanks;
    int         an_bad;

    // {sum, ovf, ones Seg, tens Seg, ones Dp}, active-low patterns
    vecs[0] = '{4'b0111, 1'b0, 7'h78, 7'h7F, 1'b1};  // 7
    vecs[1] = '{4'b1010, 1'b0, 7'h40, 7'h79, 1'b1};  // 10
    vecs[2] = '{4'b1110, 1'b1, 7'h40, 7'h30, 1'b0};  // 30
    vecs[3] = '{4'b1100, 1'b0, 7'h24, 7'h79, 1'b1};  // 12
    vecs[4] = '{4'b0011, 1'b1, 7'h10, 7'h79, 1'b0};  // 19
    vecs[5] = '{4'b1001, 1'b1, 7'h12, 7'h24, 1'b0};  // 25
    vecs[6] = '{4'b0000, 1'b0, 7'h40, 7'h7F, 1'b1};  // 0
    vecs[7] = '{4'b1111, 1'b0, 7'h12, 7'h79, 1'b1};  // 15
    vecs[8] = '{4'b0000, 1'b1, 7'h02, 7'h79, 1'b0};  // 16
    vecs[9] = '{4'b1100, 1'b1, 7'h00, 7'h24, 1'b0};  // 28

    Rst = 1'b1; Load = 1'b0; Sum = 4'd0; Overflow = 1'b0;
    @(negedge Clk);
    check("reset_seg", {1'b0, Seg}, 8'h7F);
    check("reset_dp",  {7'd0, Dp},  8'h01);
    check("reset_an",  {6'd0, An},  8'h03);
    Rst = 1'b0;
    @(negedge Clk);
    check("release_an",  {6'd0, An},  8'h02);
    check("release_seg", {1'b0, Seg}, 8'h40);
    check("release_dp",  {7'd0, Dp},  8'h01);

    // Load on the first post-reset edge; ones after edge 2, tens after edge 5, ones after edge 9.
    foreach (vecs[i]) begin
      reset_dut();
      Load = 1'b1; Sum = vecs[i].sum; Overflow = vecs[i].ovf;
      @(negedge Clk);
      Load = 1'b0;
      @(negedge Clk);
      check($sformatf("v%0d_ones_seg", i), {1'b0, Seg}, {1'b0, vecs[i].ones_seg});
      check($sformatf("v%0d_ones_dp", i),  {7'd0, Dp},  {7'd0, vecs[i].ones_dp});
      check($sformatf("v%0d_ones_an", i),  {6'd0, An},  8'h02);
      repeat (3) @(negedge Clk);
      check($sformatf("v%0d_tens_seg", i), {1'b0, Seg}, {1'b0, vecs[i].tens_seg});
      check($sformatf("v%0d_tens_dp", i),  {7'd0, Dp},  8'h01);
      check($sformatf("v%0d_tens_an", i),  {6'd0, An},  8'h01);
      repeat (4) @(negedge Clk);
      exp_seg = vecs[i].ones_seg;
      exp_dp  = vecs[i].ones_dp;
`ifdef OVF_BLINK_EN
      if (vecs[i].ovf) begin
        exp_seg = 7'h7F;
        exp_dp  = 1'b1;
      end
`endif
      check($sformatf("v%0d_ones2_seg", i), {1'b0, Seg}, {1'b0, exp_seg});
      check($sformatf("v%0d_ones2_dp", i),  {7'd0, Dp},  {7'd0, exp_dp});
      check($sformatf("v%0d_ones2_an", i),  {6'd0, An},  8'h02);
    end

    // Mid-scan reload 7 -> 12: expected {An, Dp, Seg} after edges 1..9.
    exp_q.push_back({2'b10, 1'b1, 7'h40});
    exp_q.push_back({2'b10, 1'b1, 7'h78});
    exp_q.push_back({2'b10, 1'b1, 7'h78});
    exp_q.push_back({2'b10, 1'b1, 7'h24});
    repeat (4) exp_q.push_back({2'b01, 1'b1, 7'h79});
    exp_q.push_back({2'b10, 1'b1, 7'h24});
    reset_dut();
    Load = 1'b1; Sum = 4'b0111; Overflow = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge Clk);
      exp_w = exp_q.pop_front();
      check($sformatf("scan%0d", i), {6'd0, An},  {6'd0, exp_w[9:8]});
      check($sformatf("scan%0d_seg", i), {Dp, Seg}, exp_w[7:0]);
      if (i == 0) Load = 1'b0;
      if (i == 1) begin Load = 1'b1; Sum = 4'b1100; end
      if (i == 2) Load = 1'b0;
    end

    // Asynchronous reset while the tens digit is showing.
    repeat (4) @(negedge Clk);
    check("pre_rst_an", {6'd0, An}, 8'h01);
    #2 Rst = 1'b1;
    #1;
    check("async_rst_seg", {1'b0, Seg}, 8'h7F);
    check("async_rst_dp",  {7'd0, Dp},  8'h01);
    check("async_rst_an",  {6'd0, An},  8'h03);
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    check("post_rst_an",  {6'd0, An},  8'h02);
    check("post_rst_seg", {1'b0, Seg}, 8'h40);

`ifdef OVF_BLINK_EN
    reset_dut();
    Load = 1'b1; Sum = 4'b1110; Overflow = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
    blanks = 0; an_bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      if (Seg == 7'h7F) blanks++;
      if (An != 2'b01 && An != 2'b10) an_bad++;
    end
    check("blink30_blanks", 8'(blanks), 8'd8);
    check("blink30_an", 8'(an_bad), 8'd0);
    Load = 1'b1; Sum = 4'b0111; Overflow = 1'b0;
    @(negedge Clk);
    Load = 1'b0;
    @(negedge Clk);
    blanks = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      if (An == 2'b10 && Seg == 7'h7F) blanks++;
    end
    check("blink7_blanks", 8'(blanks), 8'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
